// File: rtl/fetch_decode.sv
// Single-issue fetch/decode front end for the R-type ALU subset.
// It requests one instruction word, decodes it, and presents one registered issue cycle per instruction.
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  read_reg_num1,
  output logic [4:0]  read_reg_num2,
  output logic [4:0]  write_reg,
  output logic [3:0]  alu_control,
  output logic        regwrite,
  output logic [31:0] pc,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALT} state_t;

  state_t      state, state_next;
  logic        legal_q;
  logic        dec_legal;
  logic [3:0]  dec_alu;

  assign imem_addr = pc;

  always_comb begin
    dec_legal = 1'b0;
    dec_alu   = '0;
    if (imem_rdata[6:0] == 7'b0110011) begin
      case ({imem_rdata[31:25], imem_rdata[14:12]})
        10'b0000000_000: begin dec_legal = 1'b1; dec_alu = 4'b0010; end
        10'b0100000_000: begin dec_legal = 1'b1; dec_alu = 4'b0110; end
        10'b0000000_111: begin dec_legal = 1'b1; dec_alu = 4'b0000; end
        10'b0000000_110: begin dec_legal = 1'b1; dec_alu = 4'b0001; end
        10'b0000000_100: begin dec_legal = 1'b1; dec_alu = 4'b0011; end
        10'b0000000_010: begin dec_legal = 1'b1; dec_alu = 4'b0111; end
        10'b0000000_001: begin dec_legal = 1'b1; dec_alu = 4'b1000; end
        10'b0000000_101: begin dec_legal = 1'b1; dec_alu = 4'b1001; end
        default:         begin dec_legal = 1'b0; dec_alu = '0;      end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = REQ;
      REQ:     if (imem_ack) state_next = ISSUE;
      ISSUE:   state_next = !legal_q ? HALT : (run ? REQ : IDLE);
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Decode happens at capture so every issue-cycle output comes straight from a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      imem_req      <= 1'b0;
      pc            <= RESET_PC;
      legal_q       <= 1'b0;
      regwrite      <= 1'b0;
      illegal       <= 1'b0;
      read_reg_num1 <= '0;
      read_reg_num2 <= '0;
      write_reg     <= '0;
      alu_control   <= '0;
    end else begin
      imem_req <= (state_next == REQ);
      regwrite <= 1'b0;
      if (state == REQ && imem_ack) begin
        legal_q <= dec_legal;
        if (dec_legal) begin
          read_reg_num1 <= imem_rdata[19:15];
          read_reg_num2 <= imem_rdata[24:20];
          write_reg     <= imem_rdata[11:7];
          alu_control   <= dec_alu;
          regwrite      <= |imem_rdata[11:7];
        end else begin
          illegal <= 1'b1;
        end
      end
      if (state == ISSUE && legal_q) pc <= pc + 32'(PC_STEP);
    end
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4, byte increment applied to PC after each issued instruction.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces all state to reset values immediately.
REQ-005 run  input  1  level enable; fetching starts or continues only while high.
REQ-006 imem_req  output  1  instruction-memory request; held high until acknowledged.
REQ-007 imem_addr  output  32  fetch address; equals pc while imem_req is high.
REQ-008 imem_ack  input  1  memory accepts the request and presents imem_rdata in the same cycle.
REQ-009 imem_rdata  input  32  instruction word, sampled only when imem_req && imem_ack.
REQ-010 read_reg_num1  output  5  rs1 field to the register-file/ALU datapath.
REQ-011 read_reg_num2  output  5  rs2 field to the datapath.
REQ-012 write_reg  output  5  rd field to the datapath.
REQ-013 alu_control  output  4  ALU operation code per REQ-022.
REQ-014 regwrite  output  1  one-cycle write strobe to the datapath.
REQ-015 pc  output  32  address of the instruction currently fetched or issued.
REQ-016 illegal  output  1  sticky flag; unsupported instruction encountered.

Function
REQ-017 FSM states SHALL be IDLE, REQ, ISSUE, HALT; all outputs registered.
REQ-018 IDLE: imem_req=0, regwrite=0; go to REQ when run=1, else stay.
REQ-019 REQ: imem_req=1, imem_addr=pc stable; on imem_ack capture imem_rdata and go to ISSUE; without ack stay in REQ indefinitely.
REQ-020 run dropping while in REQ SHALL NOT cancel the outstanding request; transaction completes and issues normally.
REQ-021 ISSUE (exactly one cycle): read_reg_num1=instr[19:15], read_reg_num2=instr[24:20], write_reg=instr[11:7], alu_control per REQ-022, regwrite=1 iff legal and rd!=0; pc<=pc+PC_STEP; next state REQ if run=1 else IDLE.
REQ-022 Legal only when opcode instr[6:0]=7'b0110011; decode {funct7,funct3}: 0000000/000 ADD->4'b0010; 0100000/000 SUB->4'b0110; 0000000/111 AND->4'b0000; 0000000/110 OR->4'b0001; 0000000/100 XOR->4'b0011; 0000000/010 SLT->4'b0111; 0000000/001 SLL->4'b1000; 0000000/101 SRL->4'b1001.
REQ-023 Any other opcode or funct combination SHALL be illegal: regwrite=0, illegal<=1, pc not incremented, next state HALT.
REQ-024 HALT: imem_req=0, regwrite=0, pc frozen at offending address; leave only via reset.
REQ-025 rd=x0 with legal encoding SHALL issue with regwrite=0 and pc increment (architectural NOP).
REQ-026 pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000 with no flag.
REQ-027 Register fields and alu_control SHALL hold their last issued values outside ISSUE; only regwrite qualifies them.
REQ-028 Issue throughput: at most one instruction per two cycles (REQ with immediate ack, then ISSUE).

Reset
REQ-029 Asserting reset in any state SHALL immediately force: state=IDLE, pc=RESET_PC, imem_req=0, regwrite=0, illegal=0, read_reg_num1=read_reg_num2=write_reg=0, alu_control=4'b0000.
REQ-030 Reset asserted mid-REQ SHALL drop imem_req in the same cycle; any ack during reset is ignored.
REQ-031 After reset deasserts, first imem_req rises no earlier than the first clock edge with run=1.

Verification
REQ-032 reset, run=1, ack tied high, rdata=32'h003100B3 (add x1,x2,x3) -> imem_addr=0, then ISSUE with rs1=2, rs2=3, rd=1, alu_control=0010, regwrite=1 one cycle, pc=4.
REQ-033 rdata=32'h40628233 (sub x4,x5,x6) with ack delayed 3 cycles -> imem_req/imem_addr stable 4 cycles, then ISSUE alu_control=0110, regwrite=1, rd=4.
REQ-034 rdata=32'h00000013 (addi, I-type) -> illegal=1, regwrite never asserted, pc frozen, imem_req stays 0 until reset.
REQ-035 rdata=32'h00208033 (add x0,x1,x2) -> ISSUE with regwrite=0, pc advances by 4, fetching continues.
REQ-036 RESET_PC=32'hFFFF_FFFC, one legal instruction -> pc=0 after ISSUE, next imem_addr=0.
REQ-037 reset pulsed while imem_req=1 and ack low -> imem_req=0 same cycle, pc=RESET_PC, illegal=0, FSM in IDLE.
